// File: rtl/my_mac_pipe_if.sv
// my_mac_pipe_if: operand/result valid-ready bundle for my_mac_pipe.
interface my_mac_pipe_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 24
);
  logic in_valid, in_ready, acc_mode, acc_first, out_valid, out_ready, ovf;
  logic [DATA_W-1:0] a, b, c;
  logic [ACC_W-1:0] p;
  modport master (
    output in_valid, a, b, c, acc_mode, acc_first, out_ready,
    input in_ready, p, out_valid, ovf
  );
  modport slave (
    input in_valid, a, b, c, acc_mode, acc_first, out_ready,
    output in_ready, p, out_valid, ovf
  );
endinterface

// File: rtl/my_mac_pipe.sv
// my_mac_pipe: 2-stage multiply-add/accumulate with valid/ready on both sides.
// Optional MY_MAC_SATURATE_EN clamps results on overflow instead of wrapping.
module my_mac_pipe #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 24,
  parameter int SIGNED = 0
) (
  input logic clk,
  input logic resetn,
  my_mac_pipe_if.slave bus
);
  localparam int PW = 2 * DATA_W;
  localparam bit SG = (SIGNED != 0);
  logic s1_valid_q, s1_valid_d, mode_q, mode_d, first_q, first_d;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d, ovf_n, s1_en, s2_en, load;
  logic [PW-1:0] prod_q, prod_d, a_x, b_x;
  logic [ACC_W-1:0] c_q, c_d, acc_q, acc_d, p_q, p_d, prod_ext, addend, res;
  logic [ACC_W:0] sum;
`ifdef MY_MAC_SATURATE_EN
  logic [ACC_W-1:0] sat;
`endif
  assign s2_en = !out_valid_q || bus.out_ready;
  assign s1_en = !s1_valid_q || s2_en;
  assign load = s2_en && s1_valid_q;
  assign bus.in_ready = s1_en;
  assign bus.out_valid = out_valid_q;
  assign bus.p = p_q;
  assign bus.ovf = ovf_q;
  always_comb begin
    a_x = SG ? PW'($signed(bus.a)) : PW'(bus.a);
    b_x = SG ? PW'($signed(bus.b)) : PW'(bus.b);
    s1_valid_d = s1_en ? bus.in_valid : s1_valid_q;
    prod_d = s1_en ? a_x * b_x : prod_q;
    c_d = s1_en ? (SG ? ACC_W'($signed(bus.c)) : ACC_W'(bus.c)) : c_q;
    mode_d = s1_en ? bus.acc_mode : mode_q;
    first_d = s1_en ? bus.acc_first : first_q;
    prod_ext = SG ? ACC_W'($signed(prod_q)) : ACC_W'(prod_q);
    addend = (mode_q && !first_q) ? acc_q : c_q;
    sum = {1'b0, addend} + {1'b0, prod_ext};
    // signed overflow: like-signed operands producing an opposite-signed sum
    ovf_n = SG ? (addend[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != addend[ACC_W-1])
               : sum[ACC_W];
`ifdef MY_MAC_SATURATE_EN
    sat = SG ? {addend[ACC_W-1], {(ACC_W-1){!addend[ACC_W-1]}}} : '1;
    res = ovf_n ? sat : sum[ACC_W-1:0];
`else
    res = sum[ACC_W-1:0];
`endif
    out_valid_d = s2_en ? s1_valid_q : out_valid_q;
    p_d = load ? res : p_q;
    ovf_d = load ? ovf_n : ovf_q;
    acc_d = (load && mode_q) ? res : acc_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      prod_q <= '0;
      c_q <= '0;
      mode_q <= 1'b0;
      first_q <= 1'b0;
      out_valid_q <= 1'b0;
      p_q <= '0;
      ovf_q <= 1'b0;
      acc_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      prod_q <= prod_d;
      c_q <= c_d;
      mode_q <= mode_d;
      first_q <= first_d;
      out_valid_q <= out_valid_d;
      p_q <= p_d;
      ovf_q <= ovf_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: tb/tb_my_mac_pipe.sv
// tb_my_mac_pipe: directed vectors for my_mac_pipe; three instances (default, ACC_W=16, SIGNED=1) share one stimulus.
module tb_my_mac_pipe;
  logic clk = 1'b0;
  logic resetn, in_valid, acc_mode, acc_first, out_ready;
  logic [7:0] a, b, c;
  int total = 0;
  int pass = 0;

  always #5 clk = ~clk;

  my_mac_pipe_if #(.DATA_W(8), .ACC_W(24)) bi0();
  my_mac_pipe_if #(.DATA_W(8), .ACC_W(16)) bi16();
  my_mac_pipe_if #(.DATA_W(8), .ACC_W(24)) bis();

  assign {bi0.in_valid, bi0.a, bi0.b, bi0.c, bi0.acc_mode, bi0.acc_first, bi0.out_ready} =
         {in_valid, a, b, c, acc_mode, acc_first, out_ready};
  assign {bi16.in_valid, bi16.a, bi16.b, bi16.c, bi16.acc_mode, bi16.acc_first, bi16.out_ready} =
         {in_valid, a, b, c, acc_mode, acc_first, out_ready};
  assign {bis.in_valid, bis.a, bis.b, bis.c, bis.acc_mode, bis.acc_first, bis.out_ready} =
         {in_valid, a, b, c, acc_mode, acc_first, out_ready};

  my_mac_pipe #(.DATA_W(8), .ACC_W(24), .SIGNED(0)) u0 (.clk(clk), .resetn(resetn), .bus(bi0.slave));
  my_mac_pipe #(.DATA_W(8), .ACC_W(16), .SIGNED(0)) u16 (.clk(clk), .resetn(resetn), .bus(bi16.slave));
  my_mac_pipe #(.DATA_W(8), .ACC_W(24), .SIGNED(1)) us (.clk(clk), .resetn(resetn), .bus(bis.slave));

  typedef struct {
    logic [7:0] a, b, c;
    logic m, f;
    logic [23:0] p;
    logic o;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic beat(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] tc,
                      input logic tm, input logic tf, output int lat);
    a = ta; b = tb_; c = tc; acc_mode = tm; acc_first = tf;
    in_valid = 1'b1; out_ready = 1'b1; lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!bi0.out_valid && lat < 10);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    vec_t v[9];
    int lat, got, idx, stall;
    logic seen, blocked, prev_stall, accd;
    logic [23:0] prev_p;
    int exp_bp[4];
    v[0] = '{8'd200, 8'd100, 8'd55, 1'b0, 1'b0, 24'd20055, 1'b0};
    v[1] = '{8'd10, 8'd10, 8'd5, 1'b1, 1'b1, 24'd105, 1'b0};
    v[2] = '{8'd3, 8'd4, 8'd99, 1'b1, 1'b0, 24'd117, 1'b0};
    v[3] = '{8'd255, 8'd255, 8'd0, 1'b1, 1'b0, 24'd65142, 1'b0};
    v[4] = '{8'd1, 8'd1, 8'd0, 1'b1, 1'b1, 24'd1, 1'b0};
    v[5] = '{8'd0, 8'd0, 8'd7, 1'b0, 1'b1, 24'd7, 1'b0};
    v[6] = '{8'd2, 8'd2, 8'd0, 1'b1, 1'b0, 24'd5, 1'b0};
    v[7] = '{8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 24'd65280, 1'b0};
    v[8] = '{8'd253, 8'd7, 8'd246, 1'b0, 1'b0, 24'd2017, 1'b0};
    exp_bp = '{1, 7, 22, 45};
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'd200; b = 8'd100; c = 8'd55; acc_mode = 1'b0; acc_first = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bi0.out_valid, 0);
    chk("rst_p", bi0.p, 0);
    chk("rst_ovf", bi0.ovf, 0);
    chk("rst_p16", bi16.p, 0);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      beat(v[i].a, v[i].b, v[i].c, v[i].m, v[i].f, lat);
      chk($sformatf("v%0d_lat", i), lat, 2);
      chk($sformatf("v%0d_p", i), bi0.p, v[i].p);
      chk($sformatf("v%0d_ovf", i), bi0.ovf, v[i].o);
    end

    beat(8'hFD, 8'd7, 8'hF6, 1'b0, 1'b0, lat);
    chk("signed_p", bis.p, 24'hFFFFE1);
    chk("signed_ovf", bis.ovf, 0);

    beat(8'd255, 8'd255, 8'd255, 1'b1, 1'b1, lat);
    chk("a16_seed_p", bi16.p, 65280);
    chk("a16_seed_ovf", bi16.ovf, 0);
    beat(8'd1, 8'd1, 8'd0, 1'b1, 1'b0, lat);
    chk("a16_inc_p", bi16.p, 65281);
    chk("a16_inc_ovf", bi16.ovf, 0);
    beat(8'd255, 8'd1, 8'd0, 1'b1, 1'b0, lat);
`ifdef MY_MAC_SATURATE_EN
    chk("a16_ovf_p", bi16.p, 65535);
`else
    chk("a16_ovf_p", bi16.p, 0);
`endif
    chk("a16_ovf_flag", bi16.ovf, 1);
    beat(8'd1, 8'd1, 8'd0, 1'b1, 1'b0, lat);
`ifdef MY_MAC_SATURATE_EN
    chk("a16_after_p", bi16.p, 65535);
    chk("a16_after_ovf", bi16.ovf, 1);
`else
    chk("a16_after_p", bi16.p, 1);
    chk("a16_after_ovf", bi16.ovf, 0);
`endif

    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    got = 0; idx = 0; stall = 0; seen = 1'b0; blocked = 1'b0; prev_stall = 1'b0; prev_p = '0;
    a = 8'd1; b = 8'd1; c = 8'd0; acc_mode = 1'b0; acc_first = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("bp_hold_p", bi0.p, prev_p);
        chk("bp_hold_valid", bi0.out_valid, 1);
      end
      if (bi0.out_valid && !seen) begin
        seen = 1'b1;
        stall = 3;
      end
      out_ready = (stall == 0);
      if (stall > 0) stall--;
      #1;
      if (!bi0.in_ready) blocked = 1'b1;
      prev_stall = bi0.out_valid && !out_ready;
      prev_p = bi0.p;
      if (bi0.out_valid && out_ready) begin
        chk($sformatf("bp_p%0d", got), bi0.p, exp_bp[got]);
        got++;
      end
      accd = in_valid && bi0.in_ready;
      @(posedge clk); #1;
      if (accd) begin
        idx++;
        if (idx == 1) begin a = 8'd2; b = 8'd3; c = 8'd1; end
        else if (idx == 2) begin a = 8'd4; b = 8'd5; c = 8'd2; end
        else if (idx == 3) begin a = 8'd6; b = 8'd7; c = 8'd3; end
        else in_valid = 1'b0;
      end
    end
    chk("bp_count", got, 4);
    chk("bp_in_ready_dropped", blocked, 1);

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    a = 8'd10; b = 8'd10; c = 8'd5; acc_mode = 1'b1; acc_first = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'd3; b = 8'd4; c = 8'd0; acc_first = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_full_valid", bi0.out_valid, 1);
    chk("mid_full_in_ready", bi0.in_ready, 0);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", bi0.out_valid, 0);
    chk("mid_rst_p", bi0.p, 0);
    chk("mid_rst_ovf", bi0.ovf, 0);
    resetn = 1'b1;
    beat(8'd2, 8'd3, 8'd0, 1'b1, 1'b0, lat);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_p", bi0.p, 6);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
